// File: rtl/spi_byte_link_if.sv
`timescale 1ns/1ps
// Core-side bus of the SPI byte engine: received bytes and ready strobe
// toward the command core, response bytes and latch strobe back from it,
// plus frame status.
interface spi_byte_link_if;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic [7:0] tx_byte;
  logic       tx_latch;
  logic [1:0] byte_cnt;
  logic       frame_active;
  logic       tx_underrun;

  // Command/register core side
  modport master (
    input  rx_byte, rx_rdy, byte_cnt, frame_active, tx_underrun,
    output tx_byte, tx_latch
  );

  // SPI byte engine side
  modport slave (
    output rx_byte, rx_rdy, byte_cnt, frame_active, tx_underrun,
    input  tx_byte, tx_latch
  );
endinterface

// File: rtl/spi_byte_link.sv
`timescale 1ns/1ps
// SPI mode-0 peripheral byte engine. Oversamples sck/cs_n/mosi on sys_clk,
// assembles MSB-first receive bytes, and shifts out response bytes taken
// from a single-entry holding register written by the core.
module spi_byte_link #(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  spi_byte_link_if.slave   core
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer word layout: {sample_valid, mosi, cs_n, sck}. The valid
  // bit marks stages holding real pin samples rather than reset values, so
  // a cs_n already low at reset release is never mistaken for a fall.
  localparam logic [3:0] SYNC_RST = 4'b0010;

  state_t     state_reg, state_next;
  logic [3:0] sync_last;
  logic       sck_s, cs_s, mosi_s, valid_s;
  logic       sck_d_reg, cs_d_reg;
  logic       armed_reg, armed_next;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;

  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [1:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_byte_reg, rx_byte_next;
  logic       rx_rdy_reg, rx_rdy_next;
  logic       byte_done_reg, byte_done_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_valid_reg, hold_valid_next;
  logic       underrun_reg, underrun_next;
  logic       miso_reg, miso_next;
  logic       tx_load;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [3:0] stage_reg;
      if (gi == 0) begin : g_first
        // First stage samples the raw pins.
        always_ff @(posedge sys_clk or posedge rst) begin
          if (rst) stage_reg <= SYNC_RST;
          else     stage_reg <= {1'b1, mosi, cs_n, sck};
        end
      end else begin : g_rest
        // Later stages retime the previous stage.
        always_ff @(posedge sys_clk or posedge rst) begin
          if (rst) stage_reg <= SYNC_RST;
          else     stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign sync_last = g_sync[SYNC_STAGES-1].stage_reg;
  assign {valid_s, mosi_s, cs_s, sck_s} = sync_last;

  // Once a genuine high cs_n has been seen, frame starts are allowed.
  assign armed_next = armed_reg | (valid_s & cs_s);

  // Delayed copies for edge detection, plus the cs_n-seen-high arm flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sck_d_reg <= 1'b0;
      cs_d_reg  <= 1'b1;
      armed_reg <= 1'b0;
    end else begin
      sck_d_reg <= sck_s;
      cs_d_reg  <= cs_s;
      armed_reg <= armed_next;
    end
  end

  assign sck_rise = sck_s & ~sck_d_reg;
  assign sck_fall = ~sck_s & sck_d_reg;
  assign cs_fall  = armed_reg & cs_d_reg & ~cs_s;
  assign cs_rise  = cs_s & ~cs_d_reg;

  // Frame state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state, shifting, byte retirement and holding-register updates.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    rx_shift_next   = rx_shift_reg;
    rx_byte_next    = rx_byte_reg;
    rx_rdy_next     = 1'b0;
    byte_done_next  = 1'b0;
    tx_shift_next   = tx_shift_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    underrun_next   = underrun_reg;
    tx_load         = 1'b0;

    // A byte completed on the previous cycle is published now.
    if (byte_done_reg) begin
      rx_byte_next  = rx_shift_reg;
      rx_rdy_next   = 1'b1;
      byte_cnt_next = byte_cnt_reg + 2'd1;
    end

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next    = ACTIVE;
          bit_cnt_next  = 3'd0;
          byte_cnt_next = 2'd0;
          underrun_next = 1'b0;
          tx_load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Partial byte is abandoned; rx_byte keeps its last value.
          state_next   = IDLE;
          bit_cnt_next = 3'd0;
        end else if (sck_rise) begin
          rx_shift_next  = {rx_shift_reg[6:0], mosi_s};
          bit_cnt_next   = bit_cnt_reg + 3'd1;
          byte_done_next = (bit_cnt_reg == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_reg != 3'd0) begin
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          end else begin
            // Byte boundary: next response byte comes from hold.
            tx_load = 1'b1;
            if (!hold_valid_reg) underrun_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Transfer uses the old hold content; a same-cycle latch refills hold.
    if (tx_load) begin
      tx_shift_next   = hold_valid_reg ? hold_reg : 8'h00;
      hold_valid_next = 1'b0;
    end
    if (core.tx_latch) begin
      hold_next       = core.tx_byte;
      hold_valid_next = 1'b1;
    end

    miso_next = (state_reg == ACTIVE) & tx_shift_reg[7];
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg    <= 3'd0;
      byte_cnt_reg   <= 2'd0;
      rx_shift_reg   <= 8'h00;
      rx_byte_reg    <= 8'h00;
      rx_rdy_reg     <= 1'b0;
      byte_done_reg  <= 1'b0;
      tx_shift_reg   <= 8'h00;
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      miso_reg       <= 1'b0;
    end else begin
      bit_cnt_reg    <= bit_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      rx_shift_reg   <= rx_shift_next;
      rx_byte_reg    <= rx_byte_next;
      rx_rdy_reg     <= rx_rdy_next;
      byte_done_reg  <= byte_done_next;
      tx_shift_reg   <= tx_shift_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      underrun_reg   <= underrun_next;
      miso_reg       <= miso_next;
    end
  end

  assign miso              = miso_reg;
  assign miso_oe           = (state_reg == ACTIVE);
  assign core.frame_active = (state_reg == ACTIVE);
  assign core.rx_byte      = rx_byte_reg;
  assign core.rx_rdy       = rx_rdy_reg;
  assign core.byte_cnt     = byte_cnt_reg;
  assign core.tx_underrun  = underrun_reg;

endmodule

// File: tb/tb_spi_byte_link.sv
`timescale 1ns/1ps
// Bench for spi_byte_link: the bench plays both SPI host and command core,
// predicts received bytes, byte counts, response bytes and underrun from a
// transaction-level model, and checks every rx_rdy strobe as it happens.
module tb_spi_byte_link;
  localparam int S = 2;  // synchronizer depth
  localparam int H = 4;  // sys_clk cycles per SCK half-period

  logic sys_clk, rst, sck, cs_n, mosi, miso, miso_oe;
  spi_byte_link_if bus();

  spi_byte_link #(.SYNC_STAGES(S)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .core    (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int errors = 0;
  int checks = 0;
  int rdy_count = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Transaction-level model state
  logic [7:0] m_hold = 8'h00;
  logic       m_hold_valid = 1'b0;
  logic [7:0] m_tx = 8'h00;
  logic       m_underrun = 1'b0;
  logic       m_frame = 1'b0;
  logic [1:0] m_idx = 2'd0;
  logic       prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_hold_valid = 1'b0;
    m_underrun   = 1'b0;
    m_frame      = 1'b0;
    m_idx        = 2'd0;
    exp_q.delete();
  endtask

  task automatic model_latch(input logic [7:0] v);
    m_hold       = v;
    m_hold_valid = 1'b1;
  endtask

  task automatic model_boundary();
    if (m_hold_valid) begin
      m_tx         = m_hold;
      m_hold_valid = 1'b0;
    end else begin
      m_tx       = 8'h00;
      m_underrun = 1'b1;
    end
  endtask

  task automatic core_latch(input logic [7:0] v);
    @(negedge sys_clk);
    bus.tx_byte  = v;
    bus.tx_latch = 1'b1;
    model_latch(v);
    @(negedge sys_clk);
    bus.tx_latch = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"},         32'(miso),             0);
    chk({tag, "_miso_oe"},      32'(miso_oe),          0);
    chk({tag, "_frame_active"}, 32'(bus.frame_active), 0);
    chk({tag, "_tx_underrun"},  32'(bus.tx_underrun),  0);
    chk({tag, "_rx_byte"},      32'(bus.rx_byte),      0);
    chk({tag, "_rx_rdy"},       32'(bus.rx_rdy),       0);
    chk({tag, "_byte_cnt"},     32'(bus.byte_cnt),     0);
  endtask

  task automatic frame_begin();
    @(negedge sys_clk);
    cs_n       = 1'b0;
    m_frame    = 1'b1;
    m_idx      = 2'd0;
    m_underrun = 1'b0;
    m_tx       = m_hold_valid ? m_hold : 8'h00;
    m_hold_valid = 1'b0;
    repeat (S + 4) @(negedge sys_clk);
    chk("frame_active_on", 32'(bus.frame_active), 1);
    chk("miso_oe_on",      32'(miso_oe),          1);
  endtask

  task automatic frame_end();
    @(negedge sys_clk);
    cs_n    = 1'b1;
    m_frame = 1'b0;
    repeat (S + 4) @(negedge sys_clk);
    chk("frame_active_off", 32'(bus.frame_active), 0);
    chk("miso_oe_off",      32'(miso_oe),          0);
    chk("miso_idle",        32'(miso),             0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rx_rdy: %0d byte(s) never strobed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Host shifts nbits of b MSB first while sampling miso before each rise.
  // mode 0: no core latch; 1: latch lv before the byte boundary load;
  // 2: latch lv in the very cycle of the boundary load.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int mode,
                           input logic [7:0] lv, output logic [7:0] got);
    logic [7:0] exp_tx;
    exp_tx = m_frame ? m_tx : 8'h00;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      got[7-i] = miso;
      mosi = b[7-i];
      sck  = 1'b1;
      if (i == 7 && m_frame) begin
        m_idx = m_idx + 2'd1;
        exp_q.push_back(exp_t'({b, m_idx}));
      end
      repeat (H) @(negedge sys_clk);
      sck = 1'b0;
      if (i == 7) begin
        if (mode == 1) model_latch(lv);
        if (m_frame)   model_boundary();
        if (mode == 2) model_latch(lv);
        for (int k = 1; k <= H; k++) begin
          @(negedge sys_clk);
          bus.tx_latch = 1'b0;
          if ((mode == 1 && k == 1) || (mode == 2 && k == S)) begin
            bus.tx_byte  = lv;
            bus.tx_latch = 1'b1;
          end
        end
        bus.tx_latch = 1'b0;
      end else begin
        repeat (H) @(negedge sys_clk);
      end
    end
    if (nbits == 8) begin
      chk("miso_byte", 32'(got), 32'(exp_tx));
      $display("xfer: mosi=%02h miso=%02h (expected %02h)", b, got, exp_tx);
    end
  endtask

  // Every strobe must be expected, single-cycle, and carry the predicted data.
  always @(posedge sys_clk) begin
    #1;
    if (rst) begin
      prev_rdy <= 1'b0;
    end else begin
      if (bus.rx_rdy) begin
        rdy_count++;
        chk("rx_rdy_single_cycle", 32'(prev_rdy), 0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx_rdy: got strobe with rx_byte=%02h, required none", bus.rx_byte);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte",     32'(bus.rx_byte),     32'(e.b));
          chk("byte_cnt",    32'(bus.byte_cnt),    32'(e.cnt));
          chk("tx_underrun", 32'(bus.tx_underrun), 32'(m_underrun));
          $display("rx: byte=%02h cnt=%0d underrun=%0d", bus.rx_byte, bus.byte_cnt, bus.tx_underrun);
        end
      end
      prev_rdy <= bus.rx_rdy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g0, g1, g2, g;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus.tx_byte = 8'h00; bus.tx_latch = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (S + 3) @(negedge sys_clk);

    // Single receive, then a trailing boundary with no response queued
    frame_begin();
    send_bits(8'hA5, 8, 0, 8'h00, g);
    chk("single_rx_byte", 32'(bus.rx_byte), 'hA5);
    chk("single_byte_cnt", 32'(bus.byte_cnt), 1);
    chk("single_rdy_count", 32'(rdy_count), 1);
    chk("single_miso", 32'(g), 'h00);
    chk("single_underrun", 32'(bus.tx_underrun), 1);

    // Reset mid-frame after 5 bits with a response pending in hold
    core_latch(8'h77);
    send_bits(8'h0F, 5, 0, 8'h00, g);
    @(posedge sys_clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_frame");
    model_reset();
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    send_bits(8'hFF, 8, 0, 8'h00, g);   // cs_n still low: must be ignored
    chk("post_reset_rdy_count", 32'(rdy_count), 1);
    chk("post_reset_frame_active", 32'(bus.frame_active), 0);
    frame_end();

    // Three-byte write frame with responses supplied ahead of each boundary
    frame_begin();
    send_bits(8'h84, 8, 1, 8'hE1, g0);
    send_bits(8'h12, 8, 1, 8'hE2, g1);
    send_bits(8'h34, 8, 1, 8'hE3, g2);
    chk("write_first_miso_hold_cleared", 32'(g0), 'h00);
    chk("write_miso1", 32'(g1), 'hE1);
    chk("write_miso2", 32'(g2), 'hE2);
    chk("write_byte_cnt", 32'(bus.byte_cnt), 3);
    chk("write_rx_byte", 32'(bus.rx_byte), 'h34);
    chk("write_underrun", 32'(bus.tx_underrun), 0);
    frame_end();

    // Read response: 0x5A after first byte, 0xC3 after second
    frame_begin();
    send_bits(8'h04, 8, 1, 8'h5A, g0);
    send_bits(8'h00, 8, 1, 8'hC3, g1);
    send_bits(8'h00, 8, 1, 8'h99, g2);
    chk("read_miso0", 32'(g0), 'h00);
    chk("read_miso1", 32'(g1), 'h5A);
    chk("read_miso2", 32'(g2), 'hC3);
    chk("read_underrun", 32'(bus.tx_underrun), 0);
    frame_end();

    // Read response with the second latch omitted
    frame_begin();
    send_bits(8'h04, 8, 1, 8'h5A, g0);
    send_bits(8'h00, 8, 0, 8'h00, g1);
    send_bits(8'h00, 8, 0, 8'h00, g2);
    chk("omit_miso1", 32'(g1), 'h5A);
    chk("omit_miso2", 32'(g2), 'h00);
    chk("omit_underrun", 32'(bus.tx_underrun), 1);
    frame_end();

    // Latch collisions, plus a fourth byte to wrap byte_cnt
    core_latch(8'h11);
    core_latch(8'h22);
    frame_begin();
    core_latch(8'h44);
    send_bits(8'hAA, 8, 2, 8'h33, g0);
    send_bits(8'h55, 8, 0, 8'h00, g1);
    send_bits(8'h66, 8, 0, 8'h00, g2);
    chk("coll_last_wins", 32'(g0), 'h22);
    chk("coll_old_hold", 32'(g1), 'h44);
    chk("coll_new_next", 32'(g2), 'h33);
    send_bits(8'h77, 8, 0, 8'h00, g);
    chk("wrap_byte_cnt", 32'(bus.byte_cnt), 0);
    frame_end();

    // Abort after 4 bits, then a clean frame
    frame_begin();
    send_bits(8'hF0, 4, 0, 8'h00, g);
    frame_end();
    chk("abort_rx_byte_kept", 32'(bus.rx_byte), 'h77);
    chk("abort_rdy_count", 32'(rdy_count), 14);
    frame_begin();
    send_bits(8'h3C, 8, 0, 8'h00, g);
    chk("after_abort_rx_byte", 32'(bus.rx_byte), 'h3C);
    chk("after_abort_byte_cnt", 32'(bus.byte_cnt), 1);
    frame_end();
    chk("final_rdy_count", 32'(rdy_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
